// File: rtl/multicycle_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB over
// variable-latency instruction and data memories. It traps on an illegal
// opcode or a memory timeout and counts retired instructions.
//
// Handshake: a request (imem_req / dmem_req) is held high until the matching
// ready is sampled high on a rising CLK edge. The transfer completes in that
// cycle. A ready seen while its request is low is ignored.
module multicycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int FLAG_W   = 8,
  parameter int COND_W   = 4,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op_code,
  input  logic [FLAG_W-1:0] flags,
  input  logic [COND_W-1:0] cond,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  output logic              imem_req,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              reg_we,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              sigext_high,
  output logic [3:0]        alu_op,
  output logic [2:0]        state,
  output logic              trap,
  output logic [CNT_W-1:0]  retired
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BR   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                trap_q;
  logic [CNT_W-1:0]    retired_q;
  logic                retire;

  logic is_r, is_addi, is_ori, is_lw, is_sw, is_br, is_j, is_legal;
  logic br_taken;

  // Opcode class flags from the instruction register
  always_comb begin
    is_r     = (op_code == OP_R);
    is_addi  = (op_code == OP_ADDI);
    is_ori   = (op_code == OP_ORI);
    is_lw    = (op_code == OP_LW);
    is_sw    = (op_code == OP_SW);
    is_br    = (op_code == OP_BR);
    is_j     = (op_code == OP_J);
    is_legal = is_r | is_addi | is_ori | is_lw | is_sw | is_br | is_j;
  end

  // Datapath decode; stable for the whole instruction because the IR only
  // reloads at the end of FETCH
  always_comb begin
    reg_dst     = is_r;
    alu_src     = is_addi | is_ori | is_lw | is_sw;
    mem_to_reg  = is_lw;
    sigext_high = is_addi | is_lw | is_sw | is_br;
    alu_op      = 4'b0000;
    if (is_r)                   alu_op = 4'b1111;
    if (is_addi | is_lw | is_sw) alu_op = 4'b0001;
    if (is_ori)                 alu_op = 4'b0011;
    if (is_br)                  alu_op = 4'b0010;
  end

  // Branch condition: all-ones means always; an index past the flag vector never matches
  always_comb begin
    br_taken = &cond;
    for (int i = 0; i < FLAG_W; i++) begin
      if ((int'(cond) == i) && flags[i]) br_taken = 1'b1;
    end
  end

  // Next state, wait counter and strobes from the registered state (Mealy on ready)
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    retire   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 2'd0;
    reg_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_j) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!is_legal) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_br) begin
          pc_we   = br_taken;
          pc_src  = 2'd1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // While reset is asserted only the fetch request is shown
    if (!rst_n) begin
      imem_req = 1'b1;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      pc_src   = 2'd0;
      reg_we   = 1'b0;
      retire   = 1'b0;
    end
  end

  // State, wait counter, sticky trap and retired counter registers
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      trap_q  <= trap_q | (state_d == S_TRAP);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule
